// File: rtl/dense1_deserial_if.sv
// Stream-in / vector-out bundle for the dense-layer frame deserializer.
// The producer side (master) drives the serial stream and the consumer's
// ready; the deserializer (slave) returns the packed vector and status.
interface dense1_deserial_if #(
  parameter int N  = 120,
  parameter int DW = 16,
  parameter int CW = 8
);
  logic              frame_start;
  logic              frame_end;
  logic              valid;
  logic [DW-1:0]     data_in;
  logic [N*DW-1:0]   vec_out;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;
  logic [CW-1:0]     word_cnt;

  modport master (
    output frame_start, frame_end, valid, data_in, out_ready,
    input  vec_out, out_valid, frame_err, overrun, word_cnt
  );

  modport slave (
    input  frame_start, frame_end, valid, data_in, out_ready,
    output vec_out, out_valid, frame_err, overrun, word_cnt
  );
endinterface

// File: rtl/dense1_deserial.sv
// Frame deserializer: gathers N signed DW-bit words between frame_start and
// frame_end into a collect buffer, then hands the whole frame to a registered
// output stage guarded by a valid/ready handshake. The collect buffer lets the
// next frame stream in while the previous vector is still waiting.
module dense1_deserial #(
  parameter int N  = 120,
  parameter int DW = 16,
  parameter int CW = 8
) (
  input logic              clk,
  input logic              rst_n,
  dense1_deserial_if.slave bus
);

  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;

  logic [DW-1:0]   buf_r [N];
  logic [CW-1:0]   cnt_r;
  logic            err_r;

  logic            start_s;
  logic            wr_s;
  logic            deliver_s;
  logic            room_s;
  logic [CW-1:0]   final_cnt_s;
  logic            final_err_s;
  logic [N*DW-1:0] dvec_s;

  logic [N*DW-1:0] vec_r;
  logic            out_valid_r;
  logic            frame_err_r;
  logic            overrun_r;

  // Slot available for another word: counter has not yet reached N.
  assign room_s = (cnt_r < CW'(N));

  // Collect FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: frame_start always (re)opens a frame, a lone frame_end closes it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.frame_start) state_s = COLLECT;
        else                 state_s = IDLE;
      end
      COLLECT: begin
        if (bus.frame_start)    state_s = COLLECT;
        else if (bus.frame_end) state_s = IDLE;
        else                    state_s = COLLECT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Control strobes; a word arriving with frame_start belongs to the new frame.
  always_comb begin
    start_s   = 1'b0;
    wr_s      = 1'b0;
    deliver_s = 1'b0;
    case (state_r)
      IDLE: begin
        start_s = bus.frame_start;
      end
      COLLECT: begin
        start_s   = bus.frame_start;
        deliver_s = bus.frame_end;
        wr_s      = bus.valid & ~bus.frame_start;
      end
      default: begin
        start_s   = 1'b0;
        wr_s      = 1'b0;
        deliver_s = 1'b0;
      end
    endcase
  end

  // Count and error flag after this cycle's word (used for update and delivery).
  always_comb begin
    final_cnt_s = cnt_r;
    final_err_s = err_r;
    if (wr_s) begin
      if (room_s) begin
        final_cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        final_err_s = 1'b1;
      end
    end else begin
      final_cnt_s = cnt_r;
      final_err_s = err_r;
    end
  end

  // Delivered image: collect buffer with a coincident final word merged in.
  always_comb begin
    dvec_s = {(N*DW){1'b0}};
    for (int k = 0; k < N; k++) begin
      if (wr_s && room_s && (cnt_r == CW'(k))) begin
        dvec_s[k*DW +: DW] = bus.data_in;
      end else begin
        dvec_s[k*DW +: DW] = buf_r[k];
      end
    end
  end

  // Collect buffer, word counter and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) buf_r[k] <= {DW{1'b0}};
      cnt_r <= {CW{1'b0}};
      err_r <= 1'b0;
    end else if (start_s) begin
      for (int k = 0; k < N; k++) buf_r[k] <= {DW{1'b0}};
      if (bus.valid) begin
        buf_r[0] <= bus.data_in;
        cnt_r    <= {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r    <= {CW{1'b0}};
      end
      err_r <= 1'b0;
    end else if (wr_s) begin
      if (room_s) buf_r[cnt_r[IW-1:0]] <= bus.data_in;
      cnt_r <= final_cnt_s;
      err_r <= final_err_s;
    end
  end

  // Output register and handshake; a delivery onto an unconsumed vector flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r       <= {(N*DW){1'b0}};
      out_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (deliver_s) begin
      vec_r       <= dvec_s;
      out_valid_r <= 1'b1;
      frame_err_r <= (final_cnt_s != CW'(N)) | final_err_s;
      overrun_r   <= out_valid_r & ~bus.out_ready;
    end else begin
      overrun_r <= 1'b0;
      if (out_valid_r && bus.out_ready) out_valid_r <= 1'b0;
    end
  end

  assign bus.vec_out   = vec_r;
  assign bus.out_valid = out_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;
  assign bus.word_cnt  = cnt_r;

endmodule
